pong_engine: RTL and testbench
==============================

# pong_engine

Parametrised game-state engine for the Pong design. It holds ball, paddle and score state at configurable coordinate width and screen size, and advances one frame per `tick` strobe. It also sequences each game through idle, serve, play and game-over states. Its registered outputs feed the display/output-mux logic downstream.

## Interface
Parameters:
- `COORD_W`, 8: coordinate width in bits.
- `SCREEN_W`, 200: playfield width; x ranges over 0..SCREEN_W-1.
- `SCREEN_H`, 187: playfield height; y ranges over 0..SCREEN_H-1, and y increases downward.
- `PADDLE_EXT`, 5: paddle half-height; a paddle covers centre±PADDLE_EXT.
- `SCORE_W`, 4: width of each score counter.
- `WIN_SCORE`, 9: score that ends the game; must be ≤ 2^SCORE_W-1.
- `SERVE_TICKS`, 16: ticks the ball is held at centre before each serve.

Ports:
- `clk` in 1: clock. One clock domain only.
- `reset` in 1: synchronous, active-high reset.
- `tick` in 1: frame advance. Every clock where `tick` is high counts as one tick.
- `start` in 1: starts or restarts a game.
- `left_up`, `left_dn` in 1 each: left paddle commands.
- `right_up`, `right_dn` in 1 each: right paddle commands.
- `ball_x`, `ball_y` out COORD_W: ball position.
- `left_y`, `right_y` out COORD_W: paddle centres.
- `score_l`, `score_r` out SCORE_W: scores.
- `state` out 2: 0=IDLE, 1=SERVE, 2=PLAY, 3=OVER.
- `point` out 1: one-cycle pulse when a point is scored.
- `game_over` out 1: equals `state==OVER`.

## Operation
- Internal state: direction bits `dx` and `dy` (1 = increasing coordinate) and a serve counter.
- Reset values:
  - ball at (SCREEN_W/2, SCREEN_H/2); both paddles at SCREEN_H/2.
  - scores 0, state IDLE, `dx=dy=1`, `point=0`.
- IDLE: all state frozen. `start` clears both scores, loads the serve counter with SERVE_TICKS and goes to SERVE.
- SERVE:
  - Ball is held at centre. Each tick decrements the serve counter.
  - On the tick that finds the counter at 1, the state goes to PLAY.
  - Paddles move on ticks.
- Paddle movement, on a tick in SERVE or PLAY:
  - `up` alone decrements y; `dn` alone increments y; both or neither leaves it unchanged.
  - Result is clamped to [PADDLE_EXT, SCREEN_H-1-PADDLE_EXT].
- PLAY, each tick. All conditions use the pre-tick registered values.
  - Left hit: `ball_x==1`, `dx==0` and |ball_y-left_y| ≤ PADDLE_EXT. Sets `dx=1`.
  - Right hit: `ball_x==SCREEN_W-2`, `dx==1` and the same distance test against `right_y`. Sets `dx=0`.
  - Distance is computed at COORD_W+1 bits as a true absolute difference, with no modular wrap.
  - Top: `ball_y==0` and `dy==0` sets `dy=1`. Bottom: `ball_y==SCREEN_H-1` and `dy==1` sets `dy=0`.
  - An x bounce and a y bounce in the same tick (corner) are both applied.
  - Ball moves one step in each axis using the updated directions.
  - Miss: `ball_x==0` scores for the right player; `ball_x==SCREEN_W-1` scores for the left player.
  - On a miss the ball does not move; `point` pulses; the ball recentres.
  - After a miss, `dx` points toward the player who conceded and `dy` is unchanged.
  - After a miss, the state goes to OVER if the new score equals WIN_SCORE, else to SERVE with the counter reloaded.
- OVER: all state frozen. `start` clears scores, recentres the ball and paddles, and goes to SERVE.

## Timing
- All outputs are registered. An update is visible on the clock edge after the one where `tick` or `start` is sampled high.
- `start` is honoured in IDLE and OVER only. It does not require `tick`.
- `reset` has priority over `start` and `tick`. Asserting it mid-game restores all reset values on the next edge.
- `point` is high for exactly one clock per scored point.
- Scores never exceed WIN_SCORE.

## Configuration
- Macro: `PONG_AUTO_RIGHT_EN`.
- Defined: the right paddle is computer-driven. On each tick in SERVE or PLAY it moves one step toward `ball_y`, holds when equal, and obeys the same clamp. `right_up` and `right_dn` are ignored.
- Undefined: the right paddle follows `right_up` and `right_dn` as described above.

## Test plan
All scenarios use default parameters.
- Reset: assert `reset` → ball (100,93), `left_y=right_y=93`, scores 0, `state=0`, `point=0`.
- Serve timing: pulse `start`, then 16 ticks → `state=2` after the 16th tick with ball still at (100,93); next tick → ball (101,94).
- Clamp: hold `left_up` for 100 ticks in SERVE → `left_y` reaches 5 and stays 5. Hold `left_dn` for 200 ticks → stays 181. Both asserted → no change.
- Right hit: `right_y` tracks the ball, ball reaches x=198 → `dx=0`, next tick `ball_x=197`.
- Miss: left paddle parked at y=5, ball reaches x=0 with y>10 → `score_r=1`, one-cycle `point`, `state=1`, ball (100,93), next serve moves toward x=0.
- Win and restart: right player reaches 9 points → `state=3` and `game_over=1`; further ticks change nothing; `start` → scores 0 and `state=1`.

Source files
------------

// File: rtl/pong_engine.sv
// -----------------------------------------------------------------------------
// pong_engine
//
// Game-state engine for Pong. Holds ball, paddle and score state and advances
// one frame for every clock on which `tick` is high. A small FSM sequences each
// game through IDLE -> SERVE -> PLAY -> (SERVE | OVER). Every output is a
// register, so updates appear on the edge after `tick`/`start` is sampled.
//
// Ports:
//   clk                 clock (single domain)
//   reset               synchronous, active-high reset
//   tick                frame advance strobe
//   start               start / restart a game (honoured in IDLE and OVER)
//   left_up, left_dn    left paddle commands
//   right_up, right_dn  right paddle commands (ignored in the auto build)
//   ball_x, ball_y      ball position
//   left_y, right_y     paddle centres
//   score_l, score_r    scores
//   state               0=IDLE 1=SERVE 2=PLAY 3=OVER
//   point               one-clock pulse per scored point
//   game_over           high while state is OVER
//
// Build option:
//   PONG_AUTO_RIGHT_EN  when defined, the right paddle steps toward ball_y on
//                       each SERVE/PLAY tick and right_up/right_dn are unused.
// -----------------------------------------------------------------------------
module pong_engine #(
    parameter int COORD_W     = 8,
    parameter int SCREEN_W    = 200,
    parameter int SCREEN_H    = 187,
    parameter int PADDLE_EXT  = 5,
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_TICKS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic               left_up,
    input  logic               left_dn,
    input  logic               right_up,
    input  logic               right_dn,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic [COORD_W-1:0] left_y,
    output logic [COORD_W-1:0] right_y,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic [1:0]         state,
    output logic               point,
    output logic               game_over
);

    localparam int CNT_W = (SERVE_TICKS < 2) ? 1 : $clog2(SERVE_TICKS + 1);

    localparam logic [COORD_W-1:0] C_ZERO = {COORD_W{1'b0}};
    localparam logic [COORD_W-1:0] C_ONE  = COORD_W'(1);
    localparam logic [COORD_W-1:0] X_MID  = COORD_W'(SCREEN_W / 2);
    localparam logic [COORD_W-1:0] Y_MID  = COORD_W'(SCREEN_H / 2);
    localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] X_RHIT = COORD_W'(SCREEN_W - 2);
    localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(SCREEN_H - 1);

    // Paddle and distance arithmetic runs one bit wider so nothing wraps.
    localparam logic [COORD_W:0] W_ONE  = (COORD_W+1)'(1);
    localparam logic [COORD_W:0] PAD_LO = (COORD_W+1)'(PADDLE_EXT);
    localparam logic [COORD_W:0] PAD_HI = (COORD_W+1)'(SCREEN_H - 1 - PADDLE_EXT);
    localparam logic [COORD_W:0] EXT_W  = (COORD_W+1)'(PADDLE_EXT);

    localparam logic [SCORE_W-1:0] S_ZERO    = {SCORE_W{1'b0}};
    localparam logic [SCORE_W-1:0] S_ONE     = SCORE_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(WIN_SCORE);

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    // One paddle step with the result clamped to the legal centre range.
    function automatic logic [COORD_W-1:0] paddle_step(
        input logic [COORD_W-1:0] y,
        input logic               up,
        input logic               dn
    );
        logic [COORD_W:0] w;
        w = {1'b0, y};
        if (up && !dn) begin
            w = (w > PAD_LO) ? (w - W_ONE) : PAD_LO;
        end else if (dn && !up) begin
            w = (w < PAD_HI) ? (w + W_ONE) : PAD_HI;
        end else begin
            w = w;
        end
        if (w < PAD_LO) begin
            w = PAD_LO;
        end else if (w > PAD_HI) begin
            w = PAD_HI;
        end else begin
            w = w;
        end
        return w[COORD_W-1:0];
    endfunction

    // True absolute difference, one bit wider than the coordinates.
    function automatic logic [COORD_W:0] abs_diff(
        input logic [COORD_W-1:0] a,
        input logic [COORD_W-1:0] b
    );
        logic [COORD_W:0] ea;
        logic [COORD_W:0] eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        return (ea >= eb) ? (ea - eb) : (eb - ea);
    endfunction

    // Score increment that can never pass the winning score.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s >= SCORE_WIN) ? SCORE_WIN : (s + S_ONE);
    endfunction

    state_t             state_r,     state_nxt_s;
    logic [COORD_W-1:0] ball_x_r,    ball_x_nxt_s;
    logic [COORD_W-1:0] ball_y_r,    ball_y_nxt_s;
    logic [COORD_W-1:0] left_y_r,    left_y_nxt_s;
    logic [COORD_W-1:0] right_y_r,   right_y_nxt_s;
    logic [SCORE_W-1:0] score_l_r,   score_l_nxt_s;
    logic [SCORE_W-1:0] score_r_r,   score_r_nxt_s;
    logic               dx_r,        dx_nxt_s;
    logic               dy_r,        dy_nxt_s;
    logic [CNT_W-1:0]   serve_cnt_r, serve_cnt_nxt_s;
    logic               point_r,     point_nxt_s;
    logic               game_over_r;

    logic [COORD_W-1:0] left_step_s;
    logic [COORD_W-1:0] right_step_s;
    logic               hit_l_s;
    logic               hit_r_s;
    logic               dx_new_s;
    logic               dy_new_s;
    logic               miss_l_s;
    logic               miss_r_s;
    logic [COORD_W-1:0] ball_x_step_s;
    logic [COORD_W-1:0] ball_y_step_s;
    logic [SCORE_W-1:0] score_l_inc_s;
    logic [SCORE_W-1:0] score_r_inc_s;

`ifdef PONG_AUTO_RIGHT_EN
    // Manual right-paddle commands have no effect in this build.
    logic unused_right_cmd_s;
    assign unused_right_cmd_s = right_up ^ right_dn;
`endif

    // Candidate paddle positions for this tick; committed only in SERVE/PLAY.
    always_comb begin
        left_step_s = paddle_step(left_y_r, left_up, left_dn);
`ifdef PONG_AUTO_RIGHT_EN
        right_step_s = paddle_step(right_y_r, (ball_y_r < right_y_r), (ball_y_r > right_y_r));
`else
        right_step_s = paddle_step(right_y_r, right_up, right_dn);
`endif
    end

    // Bounce, miss and movement decisions, all from pre-tick register values.
    always_comb begin
        hit_l_s = (ball_x_r == C_ONE) && !dx_r
                  && (abs_diff(ball_y_r, left_y_r) <= EXT_W);
        hit_r_s = (ball_x_r == X_RHIT) && dx_r
                  && (abs_diff(ball_y_r, right_y_r) <= EXT_W);

        if (hit_l_s) begin
            dx_new_s = 1'b1;
        end else if (hit_r_s) begin
            dx_new_s = 1'b0;
        end else begin
            dx_new_s = dx_r;
        end

        if ((ball_y_r == C_ZERO) && !dy_r) begin
            dy_new_s = 1'b1;
        end else if ((ball_y_r == Y_MAX) && dy_r) begin
            dy_new_s = 1'b0;
        end else begin
            dy_new_s = dy_r;
        end

        // miss_l_s: ball left the field on the left, so the right player scores.
        miss_l_s = (ball_x_r == C_ZERO);
        miss_r_s = (ball_x_r == X_MAX);

        ball_x_step_s = dx_new_s ? (ball_x_r + C_ONE) : (ball_x_r - C_ONE);
        ball_y_step_s = dy_new_s ? (ball_y_r + C_ONE) : (ball_y_r - C_ONE);

        score_l_inc_s = sat_inc(score_l_r);
        score_r_inc_s = sat_inc(score_r_r);
    end

    // Next-state logic for the game FSM and all datapath registers.
    always_comb begin
        state_nxt_s     = state_r;
        ball_x_nxt_s    = ball_x_r;
        ball_y_nxt_s    = ball_y_r;
        left_y_nxt_s    = left_y_r;
        right_y_nxt_s   = right_y_r;
        score_l_nxt_s   = score_l_r;
        score_r_nxt_s   = score_r_r;
        dx_nxt_s        = dx_r;
        dy_nxt_s        = dy_r;
        serve_cnt_nxt_s = serve_cnt_r;
        point_nxt_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    score_l_nxt_s   = S_ZERO;
                    score_r_nxt_s   = S_ZERO;
                    serve_cnt_nxt_s = SERVE_LOAD;
                    state_nxt_s     = ST_SERVE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_SERVE: begin
                if (tick) begin
                    left_y_nxt_s  = left_step_s;
                    right_y_nxt_s = right_step_s;
                    // The tick that finds the counter at 1 launches the ball.
                    if (serve_cnt_r <= CNT_ONE) begin
                        serve_cnt_nxt_s = CNT_ZERO;
                        state_nxt_s     = ST_PLAY;
                    end else begin
                        serve_cnt_nxt_s = serve_cnt_r - CNT_ONE;
                    end
                end else begin
                    state_nxt_s = ST_SERVE;
                end
            end

            ST_PLAY: begin
                if (tick) begin
                    left_y_nxt_s  = left_step_s;
                    right_y_nxt_s = right_step_s;
                    if (miss_l_s || miss_r_s) begin
                        // Ball stays put this tick, then recentres; the next
                        // serve heads toward whoever conceded.
                        point_nxt_s     = 1'b1;
                        ball_x_nxt_s    = X_MID;
                        ball_y_nxt_s    = Y_MID;
                        serve_cnt_nxt_s = SERVE_LOAD;
                        if (miss_l_s) begin
                            score_r_nxt_s = score_r_inc_s;
                            dx_nxt_s      = 1'b0;
                            state_nxt_s   = (score_r_inc_s == SCORE_WIN) ? ST_OVER : ST_SERVE;
                        end else begin
                            score_l_nxt_s = score_l_inc_s;
                            dx_nxt_s      = 1'b1;
                            state_nxt_s   = (score_l_inc_s == SCORE_WIN) ? ST_OVER : ST_SERVE;
                        end
                    end else begin
                        dx_nxt_s     = dx_new_s;
                        dy_nxt_s     = dy_new_s;
                        ball_x_nxt_s = ball_x_step_s;
                        ball_y_nxt_s = ball_y_step_s;
                    end
                end else begin
                    state_nxt_s = ST_PLAY;
                end
            end

            ST_OVER: begin
                if (start) begin
                    score_l_nxt_s   = S_ZERO;
                    score_r_nxt_s   = S_ZERO;
                    ball_x_nxt_s    = X_MID;
                    ball_y_nxt_s    = Y_MID;
                    left_y_nxt_s    = Y_MID;
                    right_y_nxt_s   = Y_MID;
                    serve_cnt_nxt_s = SERVE_LOAD;
                    state_nxt_s     = ST_SERVE;
                end else begin
                    state_nxt_s = ST_OVER;
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            ball_x_r    <= X_MID;
            ball_y_r    <= Y_MID;
            left_y_r    <= Y_MID;
            right_y_r   <= Y_MID;
            score_l_r   <= S_ZERO;
            score_r_r   <= S_ZERO;
            dx_r        <= 1'b1;
            dy_r        <= 1'b1;
            serve_cnt_r <= CNT_ZERO;
            point_r     <= 1'b0;
            game_over_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            ball_x_r    <= ball_x_nxt_s;
            ball_y_r    <= ball_y_nxt_s;
            left_y_r    <= left_y_nxt_s;
            right_y_r   <= right_y_nxt_s;
            score_l_r   <= score_l_nxt_s;
            score_r_r   <= score_r_nxt_s;
            dx_r        <= dx_nxt_s;
            dy_r        <= dy_nxt_s;
            serve_cnt_r <= serve_cnt_nxt_s;
            point_r     <= point_nxt_s;
            game_over_r <= (state_nxt_s == ST_OVER);
        end
    end

    assign ball_x    = ball_x_r;
    assign ball_y    = ball_y_r;
    assign left_y    = left_y_r;
    assign right_y   = right_y_r;
    assign score_l   = score_l_r;
    assign score_r   = score_r_r;
    assign state     = state_r;
    assign point     = point_r;
    assign game_over = game_over_r;

endmodule

// File: tb/tb_pong_engine.sv
// -----------------------------------------------------------------------------
// tb_pong_engine
//
// Directed bench for pong_engine (default parameters, manual right paddle).
// The driver applies one input vector per clock and pushes hand-computed
// expectations, tagged with the cycle they become visible, into a queue. A
// separate monitor pops and compares them on the falling edge of that cycle.
// -----------------------------------------------------------------------------
module tb_pong_engine;

    localparam int S_BX = 0;
    localparam int S_BY = 1;
    localparam int S_LY = 2;
    localparam int S_RY = 3;
    localparam int S_SL = 4;
    localparam int S_SR = 5;
    localparam int S_ST = 6;
    localparam int S_PT = 7;
    localparam int S_GO = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       start;
    logic       left_up;
    logic       left_dn;
    logic       right_up;
    logic       right_dn;
    logic [7:0] ball_x;
    logic [7:0] ball_y;
    logic [7:0] left_y;
    logic [7:0] right_y;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic [1:0] state;
    logic       point;
    logic       game_over;

    pong_engine dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .start     (start),
        .left_up   (left_up),
        .left_dn   (left_dn),
        .right_up  (right_up),
        .right_dn  (right_dn),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .left_y    (left_y),
        .right_y   (right_y),
        .score_l   (score_l),
        .score_r   (score_r),
        .state     (state),
        .point     (point),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        int    sig;
        int    val;
        string name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc_cnt = 0;
    int   drv_cyc = 0;
    int   n_chk   = 0;
    int   n_pass  = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic int read_sig(input int sig);
        case (sig)
            S_BX:    return int'(ball_x);
            S_BY:    return int'(ball_y);
            S_LY:    return int'(left_y);
            S_RY:    return int'(right_y);
            S_SL:    return int'(score_l);
            S_SR:    return int'(score_r);
            S_ST:    return int'(state);
            S_PT:    return int'(point);
            S_GO:    return int'(game_over);
            default: return -1;
        endcase
    endfunction

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
            mon_e = sb_q.pop_front();
            n_chk++;
            if (mon_e.cyc < cyc_cnt) begin
                $display("FAIL %s: check skipped its cycle (due %0d, now %0d)",
                         mon_e.name, mon_e.cyc, cyc_cnt);
            end else if (read_sig(mon_e.sig) == mon_e.val) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got %0d, expected %0d",
                         mon_e.name, read_sig(mon_e.sig), mon_e.val);
            end
        end
    end

    task automatic drive(input logic r, input logic s, input logic t,
                         input logic lu, input logic ld,
                         input logic ru, input logic rd);
        @(negedge clk);
        reset    = r;
        start    = s;
        tick     = t;
        left_up  = lu;
        left_dn  = ld;
        right_up = ru;
        right_dn = rd;
        drv_cyc  = cyc_cnt;
    endtask

    task automatic run(input int n, input logic lu, input logic ld,
                       input logic ru, input logic rd);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 1'b1, lu, ld, ru, rd);
        end
    endtask

    // Expectation for the outputs after the most recently driven clock.
    task automatic want(input int sig, input int val, input string name);
        exp_t e;
        e.cyc  = drv_cyc + 1;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic want_ball(input int x, input int y, input string name);
        want(S_BX, x, {name, "_x"});
        want(S_BY, y, {name, "_y"});
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        tick     = 1'b0;
        left_up  = 1'b0;
        left_dn  = 1'b0;
        right_up = 1'b0;
        right_dn = 1'b0;

        // Reset values
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        want_ball(100, 93, "rst_ball");
        want(S_LY, 93, "rst_left_y");
        want(S_RY, 93, "rst_right_y");
        want(S_SL, 0, "rst_score_l");
        want(S_SR, 0, "rst_score_r");
        want(S_ST, 0, "rst_state");
        want(S_PT, 0, "rst_point");
        want(S_GO, 0, "rst_game_over");

        // IDLE ignores ticks and paddle commands
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        want(S_LY, 93, "idle_left_frozen");
        want(S_RY, 93, "idle_right_frozen");
        want(S_ST, 0, "idle_state");

        // start without tick
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        want(S_ST, 1, "start_serve");
        want(S_SR, 0, "start_score_r");

        // Serve timing, paddles moving during serve
        run(15, 1'b1, 1'b0, 1'b0, 1'b1);
        want(S_ST, 1, "serve_15_state");
        want(S_LY, 78, "serve_15_left");
        want(S_RY, 108, "serve_15_right");
        run(1, 1'b1, 1'b0, 1'b0, 1'b1);
        want(S_ST, 2, "serve_16_state");
        want_ball(100, 93, "serve_16_ball");
        want(S_LY, 77, "serve_16_left");
        want(S_RY, 109, "serve_16_right");

        // First play tick, with start asserted (ignored in PLAY)
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        want(S_ST, 2, "play_start_ignored");
        want_ball(101, 94, "play_1_ball");
        want(S_LY, 76, "play_1_left");

        // Paddle clamps
        run(70, 1'b1, 1'b0, 1'b0, 1'b1);
        want(S_LY, 6, "left_87_up");
        run(1, 1'b1, 1'b0, 1'b0, 1'b1);
        want(S_LY, 5, "left_88_up_clamp");
        want(S_RY, 181, "right_88_dn_clamp");
        run(12, 1'b1, 1'b0, 1'b0, 1'b1);
        want(S_LY, 5, "left_100_up_clamp");

        // Right hit at x=198 turns the ball
        run(14, 1'b1, 1'b0, 1'b0, 1'b1);
        want_ball(198, 181, "pre_hit_ball");
        run(1, 1'b1, 1'b0, 1'b0, 1'b1);
        want_ball(197, 180, "post_hit_ball");
        want(S_ST, 2, "post_hit_state");

        // Miss at the left edge
        run(197, 1'b1, 1'b0, 1'b0, 1'b1);
        want_ball(0, 17, "edge_ball");
        want(S_SR, 0, "edge_score_r");
        want(S_PT, 0, "edge_point");
        run(1, 1'b1, 1'b0, 1'b0, 1'b1);
        want(S_SR, 1, "miss1_score_r");
        want(S_SL, 0, "miss1_score_l");
        want(S_PT, 1, "miss1_point");
        want(S_ST, 1, "miss1_state");
        want_ball(100, 93, "miss1_ball");
        want(S_LY, 5, "miss1_left");

        // Second serve heads toward x=0; left paddle moved back to 93
        run(1, 1'b0, 1'b1, 1'b0, 1'b0);
        want(S_PT, 0, "point_one_cycle");
        want(S_LY, 6, "left_dn_1");
        run(15, 1'b0, 1'b1, 1'b0, 1'b0);
        want(S_ST, 2, "serve2_play");
        run(1, 1'b0, 1'b1, 1'b0, 1'b0);
        want_ball(99, 94, "serve2_ball");
        run(71, 1'b0, 1'b1, 1'b0, 1'b0);
        want(S_LY, 93, "left_parked_mid");
        run(29, 1'b0, 1'b0, 1'b0, 1'b0);
        want(S_SR, 2, "score_r_2");
        want(S_PT, 1, "point_2");
        want(S_ST, 1, "state_2");

        // Remaining points to the win
        for (int p = 3; p <= 9; p++) begin
            run(117, 1'b0, 1'b0, 1'b0, 1'b0);
            want(S_SR, p, $sformatf("score_r_%0d", p));
            want(S_PT, 1, $sformatf("point_%0d", p));
            want(S_ST, (p == 9) ? 3 : 1, $sformatf("state_%0d", p));
        end
        want(S_GO, 1, "win_game_over");
        want(S_SL, 0, "win_score_l");
        want_ball(100, 93, "win_ball");

        // OVER is frozen
        run(5, 1'b1, 1'b0, 1'b1, 1'b0);
        want(S_ST, 3, "over_state");
        want(S_SR, 9, "over_score_r");
        want(S_LY, 93, "over_left");
        want(S_RY, 181, "over_right");
        want(S_PT, 0, "over_point");

        // Restart from OVER
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        want(S_ST, 1, "restart_state");
        want(S_SR, 0, "restart_score_r");
        want(S_RY, 93, "restart_right");
        want(S_GO, 0, "restart_game_over");
        run(3, 1'b1, 1'b0, 1'b0, 1'b0);
        want(S_LY, 90, "restart_left_moves");

        // Reset mid-game
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        want(S_ST, 0, "midrst_state");
        want(S_LY, 93, "midrst_left");
        want_ball(100, 93, "midrst_ball");

        // Downward clamp, then both commands together
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        want(S_ST, 1, "game2_serve");
        run(87, 1'b0, 1'b1, 1'b0, 1'b0);
        want(S_LY, 180, "left_87_dn");
        run(1, 1'b0, 1'b1, 1'b0, 1'b0);
        want(S_LY, 181, "left_88_dn_clamp");
        run(112, 1'b0, 1'b1, 1'b0, 1'b0);
        want(S_LY, 181, "left_200_dn_clamp");
        run(10, 1'b1, 1'b1, 1'b0, 1'b0);
        want(S_LY, 181, "left_both_hold");
        want(S_SL, 1, "game2_score_l");
        want(S_SR, 0, "game2_score_r");
        want(S_ST, 2, "game2_state");

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_chk++;
            $display("FAIL %s: never compared (due cycle %0d)", mon_e.name, mon_e.cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
